alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds correct bitwise logic, shifts, set-less-than, real zero/carry/overflow flags, and iterative unsigned multiply and divide.
- Sits in the execute stage; uses a valid/ready handshake so the control unit stalls while a multi-cycle operation runs.
- Single-cycle operations complete in 1 cycle; MUL/DIV complete in WIDTH+1 cycles.

---
 rtl/alu_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready handshake.
// Single-cycle ops answer in one cycle; MUL/DIV iterate one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIV  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_valid;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic             r_dz;

  logic             w_accept;
  logic             w_last;
  logic             w_mc_start;
  logic             w_is_mul;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_sc_res;
  logic [WIDTH-1:0] w_sc_hi;
  logic             w_sc_carry;
  logic             w_sc_ovf;
  logic             w_sc_dz;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_sub;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH-1:0] w_iter_lo;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_is_mul  = (ALUControl == OP_MUL);
  // Division by zero is resolved immediately, so it never enters the iterative path.
  assign w_mc_start = w_accept &&
                      (w_is_mul || ((ALUControl == OP_DIV) && (srcB != {WIDTH{1'b0}})));

  assign w_sum = {1'b0, srcA} + {1'b0, srcB};
  assign w_sub = {1'b0, srcA} - {1'b0, srcB};

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mc_start) begin
          w_state_nxt = w_is_mul ? S_MUL : S_DIV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle result and flags, computed from the operands being accepted
  always_comb begin
    w_sc_res   = srcA;
    w_sc_hi    = {WIDTH{1'b0}};
    w_sc_carry = 1'b0;
    w_sc_ovf   = 1'b0;
    w_sc_dz    = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        w_sc_res   = w_sum[WIDTH-1:0];
        w_sc_carry = w_sum[WIDTH];
        w_sc_ovf   = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (w_sum[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res   = w_sub[WIDTH-1:0];
        w_sc_carry = ~w_sub[WIDTH];
        w_sc_ovf   = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (w_sub[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_AND:  w_sc_res = srcA & srcB;
      OP_OR:   w_sc_res = srcA | srcB;
      OP_XOR:  w_sc_res = srcA ^ srcB;
      OP_NOR:  w_sc_res = ~(srcA | srcB);
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      OP_SLL:  w_sc_res = srcA << srcB[SHW-1:0];
      OP_SRL:  w_sc_res = srcA >> srcB[SHW-1:0];
      OP_SRA:  w_sc_res = $unsigned($signed(srcA) >>> srcB[SHW-1:0]);
      OP_DIV: begin
        w_sc_res = {WIDTH{1'b1}};
        w_sc_hi  = srcA;
        w_sc_dz  = 1'b1;
      end
      default: w_sc_res = srcA;
    endcase
  end

  // One multiply (shift-add) or divide (restoring) step on the working registers
  always_comb begin
    w_iter_hi = r_hi;
    w_iter_lo = r_lo;
    if (r_state == S_MUL) begin
      w_iter_hi = w_mul_sum[WIDTH:1];
      w_iter_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      w_iter_hi = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
      w_iter_lo = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_iter_hi = r_hi;
      w_iter_lo = r_lo;
    end
  end

  // Datapath: working registers stay internal; outputs change only with out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= {CW{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_valid  <= 1'b0;
      r_res    <= {WIDTH{1'b0}};
      r_res_hi <= {WIDTH{1'b0}};
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mc_start) begin
            r_cnt <= {CW{1'b0}};
            r_hi  <= {WIDTH{1'b0}};
            r_lo  <= w_is_mul ? srcB : srcA;
            r_b   <= w_is_mul ? srcA : srcB;
          end else if (w_accept) begin
            r_res    <= w_sc_res;
            r_res_hi <= w_sc_hi;
            r_zero   <= (w_sc_res == {WIDTH{1'b0}});
            r_carry  <= w_sc_carry;
            r_ovf    <= w_sc_ovf;
            r_dz     <= w_sc_dz;
            r_valid  <= 1'b1;
          end
        end
        S_MUL, S_DIV: begin
          r_hi <= w_iter_hi;
          r_lo <= w_iter_lo;
          if (w_last) begin
            r_cnt    <= {CW{1'b0}};
            r_res    <= w_iter_lo;
            r_res_hi <= w_iter_hi;
            r_zero   <= (w_iter_lo == {WIDTH{1'b0}});
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_valid  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign res       = r_res;
  assign res_hi    = r_res_hi;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: drivers push expected responses, monitors pop
// and compare whenever out_valid pulses. WIDTH=32 and WIDTH=8 instances.
module tb_alu_seq;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  flg;   // {zero, carry, overflow, div_zero}
    int          lat;
    int          t_acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst_n32 = 1'b0, iv32 = 1'b0, ir32, ov32, z32, c32, v32, dz32;
  logic [3:0]  op32 = 4'd0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0, r32, h32;
  logic        rst_n8 = 1'b0, iv8 = 1'b0, ir8, ov8, z8, c8, v8, dz8;
  logic [3:0]  op8 = 4'd0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, r8, h8;

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n32), .in_valid(iv32), .in_ready(ir32), .ALUControl(op32),
    .srcA(a32), .srcB(b32), .out_valid(ov32), .res(r32), .res_hi(h32),
    .zero(z32), .carry(c32), .overflow(v32), .div_zero(dz32));

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .in_valid(iv8), .in_ready(ir8), .ALUControl(op8),
    .srcA(a8), .srcB(b8), .out_valid(ov8), .res(r8), .res_hi(h8),
    .zero(z8), .carry(c8), .overflow(v8), .div_zero(dz8));

  exp_t q32[$];
  exp_t q8[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] m, r, hh, p;
    longint sa, sb, s, smax, smin;
    int sh;
    logic c, v, dz;
    m    = (64'd1 << w) - 64'd1;
    sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    smax = longint'(64'd1 << (w - 1)) - 64'sd1;
    smin = -smax - 64'sd1;
    sh   = int'(b & 64'(w - 1));
    r = 64'd0; hh = 64'd0; c = 1'b0; v = 1'b0; dz = 1'b0;
    e.lat = 1;
    case (op)
      4'd0: begin r = (a + b) & m; c = ((a + b) >> w) != 64'd0; s = sa + sb; v = (s > smax) || (s < smin); end
      4'd1: begin r = (a - b) & m; c = (a >= b); s = sa - sb; v = (s > smax) || (s < smin); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b) & m;
      4'd6: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd7: r = (a < b) ? 64'd1 : 64'd0;
      4'd8: r = (a << sh) & m;
      4'd9: r = a >> sh;
      4'd10: r = 64'(sa >>> sh) & m;
      4'd12: begin p = a * b; r = p & m; hh = (p >> w) & m; e.lat = w + 1; end
      4'd13: begin
        if (b == 64'd0) begin r = m; hh = a; dz = 1'b1; end
        else begin r = a / b; hh = a % b; e.lat = w + 1; end
      end
      default: r = a;
    endcase
    e.res = r[31:0];
    e.hi  = hh[31:0];
    e.flg = {(r == 64'd0), c, v, dz};
    e.t_acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h,
                              input logic [3:0] f, input int l);
    exp_t e;
    e.res = r; e.hi = h; e.flg = f; e.lat = l; e.t_acc = 0;
    return e;
  endfunction

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, output int t);
    int g;
    g = 0;
    @(negedge clk);
    while (!ir32 && g < 200) begin @(negedge clk); g++; end
    chk("issue32_ready_timeout", 64'(g >= 200), 64'd0);
    op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
    e.t_acc = cyc; t = cyc;
    q32.push_back(e);
    @(posedge clk); #1 iv32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, output int t);
    int g;
    g = 0;
    @(negedge clk);
    while (!ir8 && g < 200) begin @(negedge clk); g++; end
    chk("issue8_ready_timeout", 64'(g >= 200), 64'd0);
    op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
    e.t_acc = cyc; t = cyc;
    q8.push_back(e);
    @(posedge clk); #1 iv8 = 1'b0;
  endtask

  exp_t        m32_e, m8_e;
  logic [31:0] l_r32, l_h32;
  logic [7:0]  l_r8, l_h8;
  logic [3:0]  l_f32, l_f8;

  // Monitor for the 32-bit instance: scoreboard pop on out_valid, hold check otherwise.
  always @(negedge clk) begin
    if (!rst_n32) begin
      l_r32 = 32'd0; l_h32 = 32'd0; l_f32 = 4'd0;
    end else if (ov32) begin
      if (q32.size() == 0) begin
        chk("mon32_unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        m32_e = q32.pop_front();
        chk("res32", r32, m32_e.res);
        chk("res_hi32", h32, m32_e.hi);
        chk("flags32", {z32, c32, v32, dz32}, m32_e.flg);
        chk("latency32", 64'(cyc - m32_e.t_acc), 64'(m32_e.lat));
      end
      l_r32 = r32; l_h32 = h32; l_f32 = {z32, c32, v32, dz32};
    end else if ({r32, h32, z32, c32, v32, dz32} !== {l_r32, l_h32, l_f32}) begin
      n_tests++; n_fail++;
      $display("FAIL hold32: outputs %h/%h/%b changed without out_valid, held %h/%h/%b",
               r32, h32, {z32, c32, v32, dz32}, l_r32, l_h32, l_f32);
      l_r32 = r32; l_h32 = h32; l_f32 = {z32, c32, v32, dz32};
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst_n8) begin
      l_r8 = 8'd0; l_h8 = 8'd0; l_f8 = 4'd0;
    end else if (ov8) begin
      if (q8.size() == 0) begin
        chk("mon8_unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        m8_e = q8.pop_front();
        chk("res8", r8, m8_e.res[7:0]);
        chk("res_hi8", h8, m8_e.hi[7:0]);
        chk("flags8", {z8, c8, v8, dz8}, m8_e.flg);
        chk("latency8", 64'(cyc - m8_e.t_acc), 64'(m8_e.lat));
      end
      l_r8 = r8; l_h8 = h8; l_f8 = {z8, c8, v8, dz8};
    end else if ({r8, h8, z8, c8, v8, dz8} !== {l_r8, l_h8, l_f8}) begin
      n_tests++; n_fail++;
      $display("FAIL hold8: outputs %h/%h/%b changed without out_valid, held %h/%h/%b",
               r8, h8, {z8, c8, v8, dz8}, l_r8, l_h8, l_f8);
      l_r8 = r8; l_h8 = h8; l_f8 = {z8, c8, v8, dz8};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, g;
    logic [3:0]  op;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    chk("reset32_res", r32, 64'd0);
    chk("reset32_hi", h32, 64'd0);
    chk("reset32_flags", {ov32, z32, c32, v32, dz32}, 64'd0);
    chk("reset8_outs", {ov8, z8, c8, v8, dz8, r8, h8}, 64'd0);
    rst_n32 = 1'b1; rst_n8 = 1'b1;
    @(negedge clk);
    chk("ready32_after_reset", ir32, 64'd1);
    chk("ready8_after_reset", ir8, 64'd1);

    issue32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 32'd0, 4'b0010, 1), t);
    issue32(OP_SUB, 32'd5, 32'd5, mk(32'd0, 32'd0, 4'b1100, 1), t);
    issue32(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, mk(32'h00F0_00F0, 32'd0, 4'b0000, 1), t);
    issue32(OP_SRA, 32'h8000_0000, 32'd4, mk(32'hF800_0000, 32'd0, 4'b0000, 1), t);
    issue32(OP_SLT, 32'hFFFF_FFFF, 32'd1, mk(32'd1, 32'd0, 4'b0000, 1), t);
    issue32(OP_SLTU, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 32'd0, 4'b1000, 1), t);
    issue32(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0001, 32'hFFFF_FFFE, 4'b0000, 33), t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy32_in_ready", ir32, 64'd0);
      op32 = OP_ADD; a32 = $urandom; b32 = $urandom; iv32 = 1'b1;
      @(posedge clk); #1 iv32 = 1'b0;
    end
    issue32(OP_DIV, 32'd100, 32'd7, mk(32'd14, 32'd2, 4'b0000, 33), t);
    issue32(OP_DIV, 32'd100, 32'd0, mk(32'hFFFF_FFFF, 32'd100, 4'b0001, 1), t);
    issue32(OP_ADD, 32'd1, 32'd2, mk(32'd3, 32'd0, 4'b0000, 1), t);

    // Reset in the middle of a multiply: outputs clear at once, no completion follows.
    issue32(OP_MUL, 32'd7, 32'd9, model(32, OP_MUL, 64'd7, 64'd9), t);
    repeat (9) @(posedge clk);
    #2 rst_n32 = 1'b0;
    #1;
    chk("async_reset32_res", r32, 64'd0);
    chk("async_reset32_hi", h32, 64'd0);
    chk("async_reset32_flags", {ov32, z32, c32, v32, dz32}, 64'd0);
    q32.delete();
    repeat (2) @(negedge clk);
    rst_n32 = 1'b1;
    @(negedge clk);
    chk("ready32_after_midop_reset", ir32, 64'd1);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (op == OP_DIV && $urandom_range(0, 4) == 0) b = 32'd0;
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 3));
      issue32(op, a, b, model(32, op, 64'(a), 64'(b)), t);
    end

    issue8(OP_MUL, 8'd15, 8'd17, mk(32'd255, 32'd0, 4'b0000, 9), t1);
    issue8(OP_ADD, 8'd200, 8'd100, mk(32'd44, 32'd0, 4'b0100, 1), t2);
    chk("b2b8_accept_gap", 64'(t2 - t1), 64'd9);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 32'($urandom_range(0, 255));
      b  = 32'($urandom_range(0, 255));
      if (op == OP_DIV && $urandom_range(0, 4) == 0) b = 32'd0;
      issue8(op, a[7:0], b[7:0], model(8, op, 64'(a[7:0]), 64'(b[7:0])), t);
    end

    g = 0;
    while ((q32.size() != 0 || q8.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("scoreboard_drain", 64'(q32.size() + q8.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
